uart_rx_fifo: RTL and testbench

Parametrised UART receiver with configurable frame format: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits.
- Each received character is written, with its own per-frame error flags, into an internal show-ahead FIFO.
- The consumer drains the FIFO through a valid/ready port, which replaces direct writes into a consumer-owned buffer.
- Sits between the board RX pin and the CPU's memory-mapped UART register block.

---
 rtl/uart_rx_fifo_pkg.sv | 30 +++
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo_sync_fifo.sv | 51 +++++
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and helpers for the UART receiver
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // One FIFO entry: a received character with its own error flags.
    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    // System clocks per bit period.
    function automatic int sclk_period(input int freq_hz, input int baud);
        return freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - consumer-side port bundle of the UART receiver
interface uart_rx_fifo_if #(
    parameter int FifoDepth = 16
) ();
    // rx_data        head character, LSB-aligned
    // rx_parity_err  parity error flag of the head entry
    // rx_frame_err   framing error flag of the head entry
    // rx_valid       FIFO not empty
    // rx_ready       consumer pops the head when rx_valid && rx_ready
    // rx_count       current FIFO occupancy
    // overrun        sticky: a frame was dropped because the FIFO was full
    // overrun_clr    clears overrun
    logic [7:0]                   rx_data;
    logic                         rx_parity_err;
    logic                         rx_frame_err;
    logic                         rx_valid;
    logic                         rx_ready;
    logic [$clog2(FifoDepth):0]   rx_count;
    logic                         overrun;
    logic                         overrun_clr;

    modport master (
        output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_count, overrun,
        input  rx_ready, overrun_clr
    );

    modport slave (
        input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_count, overrun,
        output rx_ready, overrun_clr
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - generic show-ahead synchronous FIFO
module uart_rx_fifo_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk,        // system clock
    input  logic                     rst_n,      // synchronous active-low reset
    input  logic                     push,       // write request
    input  logic [Width-1:0]         push_data,  // write data
    input  logic                     pop,        // read request, ignored when empty
    output logic [Width-1:0]         pop_data,   // head entry, valid when !empty
    output logic                     full,       // count == Depth
    output logic                     empty,      // count == 0
    output logic [$clog2(Depth):0]   count       // occupancy
);
    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CountW'(Depth));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CountW'(1);
                2'b01:   count <= count - CountW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with per-frame error flags and show-ahead FIFO
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int           ClockFreqHz = 10_000_000,
    parameter int           BaudRate    = 9600,
    parameter int           DataBits    = 8,
    parameter parity_mode_e ParityMode  = PARITY_NONE,
    parameter int           StopBits    = 1,
    parameter int           FifoDepth   = 16
) (
    input  logic           clk,     // system clock
    input  logic           rst_n,   // synchronous active-low reset
    input  logic           rx_sig,  // asynchronous serial line, idles high
    output logic           busy,    // receiver not in IDLE
    uart_rx_fifo_if.master rx_if    // consumer port: head entry, handshake, occupancy, overrun
);
    localparam int SClkPeriod = sclk_period(ClockFreqHz, BaudRate);
    localparam int CntW       = $clog2(SClkPeriod + 1);
    localparam int CountW     = $clog2(FifoDepth) + 1;

    localparam logic [CntW-1:0] HalfM1   = CntW'(SClkPeriod / 2 - 1);
    localparam logic [CntW-1:0] FullM1   = CntW'(SClkPeriod - 1);
    localparam logic [2:0]      LastData = 3'(DataBits - 1);
    localparam logic [2:0]      LastStop = 3'(StopBits - 1);

    logic              rx_meta;
    logic              rxs;
    logic              last_rxs;

    rx_state_e         state_q, state_d;
    logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              push;

    rx_entry_t         push_entry;
    rx_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic [CountW-1:0] fifo_count;
    logic              overrun_q;

    // Two-flop synchroniser; last_rxs lets IDLE react only to a falling edge,
    // so a held-low break line is not re-received as endless frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            last_rxs <= 1'b1;
        end else begin
            rx_meta  <= rx_sig;
            rxs      <= rx_meta;
            last_rxs <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        push         = 1'b0;

        case (state_q)
            IDLE: begin
                if (last_rxs && !rxs) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end

            // Half a bit in, the start bit must still be low; otherwise it was a glitch.
            START: begin
                if (clk_cnt_q == HalfM1) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DATA;
                        bit_idx_d    = '0;
                        shift_d      = '0;
                        parity_err_d = 1'b0;
                        frame_err_d  = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            // Samples land mid-bit because the count restarted at the start-bit middle.
            DATA: begin
                if (clk_cnt_q == FullM1) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == LastData) begin
                        bit_idx_d = '0;
                        state_d   = (ParityMode == PARITY_NONE) ? STOP : PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            // Unused upper shift bits are zero, so they do not disturb the reduction.
            PARITY: begin
                if (clk_cnt_q == FullM1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = STOP;
                    if (ParityMode == PARITY_ODD) parity_err_d = ~^{shift_q, rxs};
                    else                          parity_err_d = ^{shift_q, rxs};
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            // The frame is pushed at the last stop mid-sample so the next start
            // edge can be caught during the second half of that stop bit.
            STOP: begin
                if (clk_cnt_q == FullM1) begin
                    clk_cnt_d = '0;
                    if (!rxs) frame_err_d = 1'b1;
                    if (bit_idx_q == LastStop) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign push_entry = '{frame_err: frame_err_d, parity_err: parity_err_q, data: shift_q};

    assign pop  = !fifo_empty && rx_if.rx_ready;
    assign drop = push && fifo_full && !pop;

    uart_rx_fifo_sync_fifo #(
        .Width ($bits(rx_entry_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n)                 overrun_q <= 1'b0;
        else if (drop)              overrun_q <= 1'b1;
        else if (rx_if.overrun_clr) overrun_q <= 1'b0;
    end

    // Head fields are masked while empty so stale storage never reaches the consumer.
    assign rx_if.rx_valid      = !fifo_empty;
    assign rx_if.rx_data       = fifo_empty ? 8'h00 : head.data;
    assign rx_if.rx_parity_err = !fifo_empty && head.parity_err;
    assign rx_if.rx_frame_err  = !fifo_empty && head.frame_err;
    assign rx_if.rx_count      = fifo_count;
    assign rx_if.overrun       = overrun_q;
    assign busy                = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [2:0] rx_line;
    logic       busy_a, busy_b, busy_c;
    int         n_vec;
    int         n_bad;
    int         lat_a;
    logic       saw;

    uart_rx_fifo_if #(.FifoDepth(4))  if_a ();
    uart_rx_fifo_if #(.FifoDepth(16)) if_b ();
    uart_rx_fifo_if #(.FifoDepth(4))  if_c ();

    // 8N1, shallow FIFO
    uart_rx_fifo #(
        .ClockFreqHz(1_000_000), .BaudRate(100_000), .DataBits(8),
        .ParityMode(PARITY_NONE), .StopBits(1), .FifoDepth(4)
    ) u_a (.clk(clk), .rst_n(rst_n), .rx_sig(rx_line[0]), .busy(busy_a), .rx_if(if_a));

    // 7E1
    uart_rx_fifo #(
        .ClockFreqHz(1_000_000), .BaudRate(100_000), .DataBits(7),
        .ParityMode(PARITY_EVEN), .StopBits(1), .FifoDepth(16)
    ) u_b (.clk(clk), .rst_n(rst_n), .rx_sig(rx_line[1]), .busy(busy_b), .rx_if(if_b));

    // 8N2
    uart_rx_fifo #(
        .ClockFreqHz(1_000_000), .BaudRate(100_000), .DataBits(8),
        .ParityMode(PARITY_NONE), .StopBits(2), .FifoDepth(4)
    ) u_c (.clk(clk), .rst_n(rst_n), .rx_sig(rx_line[2]), .busy(busy_c), .rx_if(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives nbits line bits, LSB first, 10 clocks each; records lane-0 rx_valid latency.
    task automatic send(input int lane, input logic [15:0] bits, input int nbits);
        for (int c = 0; c < nbits * 10; c++) begin
            rx_line[lane] = bits[c / 10];
            tick(1);
            if (lane == 0 && lat_a < 0 && if_a.rx_valid) lat_a = c + 1;
        end
    endtask

    task automatic pop(input int lane);
        case (lane)
            0:       if_a.rx_ready = 1'b1;
            1:       if_b.rx_ready = 1'b1;
            default: if_c.rx_ready = 1'b1;
        endcase
        tick(1);
        if_a.rx_ready = 1'b0;
        if_b.rx_ready = 1'b0;
        if_c.rx_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        lat_a = -1;
        rst_n = 1'b0;
        rx_line = 3'b111;
        if_a.rx_ready = 1'b0; if_a.overrun_clr = 1'b0;
        if_b.rx_ready = 1'b0; if_b.overrun_clr = 1'b0;
        if_c.rx_ready = 1'b0; if_c.overrun_clr = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        check("rst_valid",   if_a.rx_valid, 0);
        check("rst_count",   if_a.rx_count, 0);
        check("rst_data",    if_a.rx_data, 0);
        check("rst_flags",   {if_a.rx_parity_err, if_a.rx_frame_err}, 0);
        check("rst_overrun", if_a.overrun, 0);
        check("rst_busy",    busy_a, 0);

        // 8N1 0xA5: last stop sample at clock 98 after the start edge
        send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
        check("a5_latency_window", (lat_a >= 97 && lat_a <= 103), 1);
        check("a5_data",      if_a.rx_data, 8'hA5);
        check("a5_parity",    if_a.rx_parity_err, 0);
        check("a5_frame",     if_a.rx_frame_err, 0);
        check("a5_count",     if_a.rx_count, 1);
        pop(0);
        check("a5_pop_valid", if_a.rx_valid, 0);

        // 3-clock glitch: START entered at clock 3, rejected at clock 8
        saw = 1'b0;
        rx_line[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(1); saw |= busy_a; end
        rx_line[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(1); saw |= busy_a; end
        check("glitch_busy_pulse", saw, 1);
        check("glitch_idle",       busy_a, 0);
        check("glitch_count",      if_a.rx_count, 0);

        // Five frames into a 4-deep FIFO: the fifth is dropped
        for (int i = 1; i <= 5; i++) send(0, {6'h3f, 1'b1, 8'(i), 1'b0}, 10);
        check("ovr_count", if_a.rx_count, 4);
        check("ovr_flag",  if_a.overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_data", if_a.rx_data, i);
            pop(0);
        end
        check("ovr_drained", if_a.rx_valid, 0);
        check("ovr_sticky",  if_a.overrun, 1);
        if_a.overrun_clr = 1'b1;
        tick(1);
        if_a.overrun_clr = 1'b0;
        check("ovr_cleared", if_a.overrun, 0);

        // 7E1 0x03: even parity bit should be 0
        send(1, {6'h3f, 1'b1, 1'b1, 7'h03, 1'b0}, 10);
        check("e7_bad_data",   if_b.rx_data, 8'h03);
        check("e7_bad_parity", if_b.rx_parity_err, 1);
        check("e7_bad_frame",  if_b.rx_frame_err, 0);
        pop(1);
        send(1, {6'h3f, 1'b1, 1'b0, 7'h03, 1'b0}, 10);
        check("e7_ok_data",    if_b.rx_data, 8'h03);
        check("e7_ok_parity",  if_b.rx_parity_err, 0);

        // 8N2 0x5A with second stop bit low, then a clean 0x11
        send(2, {5'h1f, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        rx_line[2] = 1'b1;
        tick(20);
        check("n2_bad_data",   if_c.rx_data, 8'h5A);
        check("n2_bad_frame",  if_c.rx_frame_err, 1);
        check("n2_bad_parity", if_c.rx_parity_err, 0);
        pop(2);
        send(2, {5'h1f, 2'b11, 8'h11, 1'b0}, 11);
        check("n2_ok_data",    if_c.rx_data, 8'h11);
        check("n2_ok_frame",   if_c.rx_frame_err, 0);
        check("n2_ok_count",   if_c.rx_count, 1);

        // Reset mid-DATA with two entries queued
        send(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
        check("mid_queued", if_a.rx_count, 2);
        send(0, {12'hfff, 3'b101, 1'b0}, 4);
        check("mid_busy", busy_a, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_valid", if_a.rx_valid, 0);
        check("mid_rst_count", if_a.rx_count, 0);
        check("mid_rst_busy",  busy_a, 0);
        rx_line[0] = 1'b1;
        tick(20);
        send(0, {6'h3f, 1'b1, 8'hC3, 1'b0}, 10);
        check("post_rst_data",  if_a.rx_data, 8'hC3);
        check("post_rst_flags", {if_a.rx_parity_err, if_a.rx_frame_err}, 0);
        check("post_rst_count", if_a.rx_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
